// File: rtl/lc4_icache_memory_pkg.sv
// lc4_icache_memory_pkg: shared fill-FSM state encoding and counter sizing helper for the LC4 icache memory
package lc4_icache_memory_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} fill_state_t;
  function automatic int cnt_bits(input int miss_latency);
    return (miss_latency < 2) ? 1 : $clog2(miss_latency);
  endfunction
endpackage

// File: rtl/lc4_icache_port.sv
// lc4_icache_port: one direct-mapped instruction cache with miss FSM; ports clk/rst(active-low)/gwe, ire/addr lookup, inv/inv_addr invalidate, fill_addr/fill_data backing read, iout/istall result
module lc4_icache_port
  import lc4_icache_memory_pkg::*;
#(
  parameter int IADDR_WIDTH  = 16,
  parameter int LINE_BITS    = 4,
  parameter int MISS_LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gwe,
  input  logic                   ire,
  input  logic [IADDR_WIDTH-1:0] addr,
  input  logic                   inv,
  input  logic [IADDR_WIDTH-1:0] inv_addr,
  input  logic [15:0]            fill_data,
  output logic [IADDR_WIDTH-1:0] fill_addr,
  output logic [15:0]            iout,
  output logic                   istall
);
  localparam int LINES = 2 ** LINE_BITS;
  localparam int TW = IADDR_WIDTH - LINE_BITS;
  localparam int CW = cnt_bits(MISS_LATENCY);
  // the miss edge itself is the first stall cycle, so FILL needs MISS_LATENCY-1 cycles
  localparam logic [CW-1:0] CNT_LOAD = CW'(MISS_LATENCY > 1 ? MISS_LATENCY - 2 : 0);
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [15:0] data [LINES];
  fill_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IADDR_WIDTH-1:0] cap;
  logic [LINE_BITS-1:0] idx, fidx, iidx;
  logic hit, miss, fill_done, inv_hit;
  always_comb begin
    idx = addr[LINE_BITS-1:0];
    hit = valid[idx] && tags[idx] == addr[IADDR_WIDTH-1:LINE_BITS];
    miss = state == S_IDLE && ire && !hit;
    // a one-cycle latency fills straight from IDLE without visiting FILL
    fill_done = (state == S_FILL && cnt == '0) || (miss && MISS_LATENCY == 1);
    fill_addr = state == S_IDLE ? addr : cap;
    fidx = fill_addr[LINE_BITS-1:0];
    iidx = inv_addr[LINE_BITS-1:0];
    // a line being filled this edge is judged by its incoming address, so invalidate beats fill
    inv_hit = inv && ((fill_done && fidx == iidx) ? fill_addr == inv_addr
                      : valid[iidx] && tags[iidx] == inv_addr[IADDR_WIDTH-1:LINE_BITS]);
    state_n = (miss && MISS_LATENCY > 1) ? S_FILL : (state == S_FILL && cnt == '0) ? S_IDLE : state;
    istall = rst && (state == S_FILL || miss);
    iout = (rst && state == S_IDLE && ire && hit) ? data[idx] : 16'h0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      state <= S_IDLE;
      cnt <= '0;
    end else if (gwe) begin
      state <= state_n;
      if (miss) begin
        cap <= addr;
        cnt <= CNT_LOAD;
      end else if (state == S_FILL && cnt != '0) cnt <= cnt - 1'b1;
      if (fill_done) begin
        valid[fidx] <= 1'b1;
        tags[fidx] <= fill_addr[IADDR_WIDTH-1:LINE_BITS];
        data[fidx] <= fill_data;
      end
      if (inv_hit) valid[iidx] <= 1'b0;
    end
  end
endmodule

// File: rtl/lc4_icache_memory.sv
// lc4_icache_memory: LC4 memory with NUM_IPORTS cached instruction read ports (ire/iaddr -> iout/istall), instruction store write (iwe/iwaddr/iwdata) and data memory (dre/draddr/dout, dwe/dwaddr/din); idclk, active-low sync rst, gwe
module lc4_icache_memory
  import lc4_icache_memory_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_IPORTS   = 2,
  parameter int IADDR_WIDTH  = 16,
  parameter int LINE_BITS    = 4,
  parameter int MISS_LATENCY = 8,
  parameter bit CACHE_EN     = 1,
  parameter int DADDR_WIDTH  = 3
) (
  input  logic                              idclk,
  input  logic                              rst,
  input  logic                              gwe,
  input  logic [NUM_IPORTS-1:0]             ire,
  input  logic [NUM_IPORTS*IADDR_WIDTH-1:0] iaddr,
  output logic [NUM_IPORTS*16-1:0]          iout,
  output logic [NUM_IPORTS-1:0]             istall,
  input  logic                              iwe,
  input  logic [IADDR_WIDTH-1:0]            iwaddr,
  input  logic [15:0]                       iwdata,
  input  logic                              dre,
  input  logic [DADDR_WIDTH-1:0]            draddr,
  output logic [WORD_SIZE-1:0]              dout,
  input  logic                              dwe,
  input  logic [DADDR_WIDTH-1:0]            dwaddr,
  input  logic [WORD_SIZE-1:0]              din
);
  logic [15:0] imem [2**IADDR_WIDTH];
  logic [WORD_SIZE-1:0] dmem [2**DADDR_WIDTH];
  logic iwr;
  assign iwr = rst && gwe && iwe;
  always_ff @(posedge idclk) if (iwr) imem[iwaddr] <= iwdata;
  always_ff @(posedge idclk) begin
    if (!rst) for (int i = 0; i < 2 ** DADDR_WIDTH; i++) dmem[i] <= '0;
    else if (gwe && dwe) dmem[dwaddr] <= din;
  end
  assign dout = (rst && dre) ? dmem[draddr] : '0;
  for (genvar p = 0; p < NUM_IPORTS; p++) begin : g_port
    if (CACHE_EN) begin : g_cache
      logic [IADDR_WIDTH-1:0] fill_addr;
      lc4_icache_port #(
        .IADDR_WIDTH (IADDR_WIDTH),
        .LINE_BITS   (LINE_BITS),
        .MISS_LATENCY(MISS_LATENCY)
      ) u_port (
        .clk      (idclk),
        .rst      (rst),
        .gwe      (gwe),
        .ire      (ire[p]),
        .addr     (iaddr[p*IADDR_WIDTH +: IADDR_WIDTH]),
        .inv      (iwr),
        .inv_addr (iwaddr),
        .fill_data(imem[fill_addr]),
        .fill_addr(fill_addr),
        .iout     (iout[p*16 +: 16]),
        .istall   (istall[p])
      );
    end else begin : g_bypass
      assign iout[p*16 +: 16] = (rst && ire[p]) ? imem[iaddr[p*IADDR_WIDTH +: IADDR_WIDTH]] : 16'h0;
      assign istall[p] = 1'b0;
    end
  end
endmodule

// File: tb/tb_lc4_icache_memory.sv
// tb_lc4_icache_memory: directed checks of the cached LC4 memory plus a cache-bypassed build
module tb_lc4_icache_memory;
  logic clk = 0, rst = 0, gwe = 1, iwe = 0, dre = 0, dwe = 0;
  logic [1:0] ire = 0;
  logic [31:0] iaddr = 0;
  logic [15:0] iwaddr = 0, iwdata = 0, din = 0;
  logic [2:0] draddr = 0, dwaddr = 0;
  logic [31:0] iout, iout_nc;
  logic [1:0] istall, istall_nc;
  logic [15:0] dout, dout_nc;
  int checks = 0, errors = 0;
  bit nc_stalled = 0;

  always #5 clk = ~clk;

  lc4_icache_memory dut (
    .idclk(clk), .rst(rst), .gwe(gwe), .ire(ire), .iaddr(iaddr), .iout(iout), .istall(istall),
    .iwe(iwe), .iwaddr(iwaddr), .iwdata(iwdata), .dre(dre), .draddr(draddr), .dout(dout),
    .dwe(dwe), .dwaddr(dwaddr), .din(din)
  );
  lc4_icache_memory #(.CACHE_EN(0)) dut_nc (
    .idclk(clk), .rst(rst), .gwe(gwe), .ire(ire), .iaddr(iaddr), .iout(iout_nc), .istall(istall_nc),
    .iwe(iwe), .iwaddr(iwaddr), .iwdata(iwdata), .dre(dre), .draddr(draddr), .dout(dout_nc),
    .dwe(dwe), .dwaddr(dwaddr), .din(din)
  );

  always @(negedge clk) if (istall_nc !== 2'b00) nc_stalled = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iwrite(input logic [15:0] a, input logic [15:0] d);
    iwe = 1; iwaddr = a; iwdata = d;
    tick();
    iwe = 0;
  endtask

  task automatic miss_then_hit(input int p, input logic [15:0] a, input logic [15:0] d, input string tag);
    ire[p] = 1;
    iaddr[p*16 +: 16] = a;
    for (int i = 0; i < 8; i++) begin
      #1 chk({tag, "_stall"}, {31'b0, istall[p]}, 1);
      tick();
    end
    #1 chk({tag, "_hitstall"}, {31'b0, istall[p]}, 0);
    chk({tag, "_data"}, {16'b0, iout[p*16 +: 16]}, {16'b0, d});
  endtask

  initial begin
    int n;
    // reset: outputs forced low even with requests present
    ire = 2'b11; iaddr = {16'h0010, 16'h0010}; dre = 1;
    tick(); tick();
    chk("rst_istall", {30'b0, istall}, 0);
    chk("rst_iout", iout, 0);
    chk("rst_dout", {16'b0, dout}, 0);
    ire = 0; dre = 0; rst = 1;
    iwrite(16'h0010, 16'hABCD);
    iwrite(16'h0020, 16'h1111);
    iwrite(16'h0031, 16'h2222);
    iwrite(16'h0110, 16'h3333);
    // 1: cold miss then persistent hit
    miss_then_hit(0, 16'h0010, 16'hABCD, "t1");
    tick();
    chk("t1_hold_stall", {31'b0, istall[0]}, 0);
    chk("t1_hold_data", {16'b0, iout[15:0]}, 32'hABCD);
    // 2: both ports miss together
    ire = 2'b11; iaddr = {16'h0031, 16'h0020};
    for (int i = 0; i < 8; i++) begin
      #1 chk("t2_stall", {30'b0, istall}, 2'b11);
      tick();
    end
    #1 chk("t2_hitstall", {30'b0, istall}, 0);
    chk("t2_data", iout, {16'h2222, 16'h1111});
    ire = 0;
    // 3: conflicting tags on index 0
    miss_then_hit(0, 16'h0010, 16'hABCD, "t3a");
    miss_then_hit(0, 16'h0110, 16'h3333, "t3b");
    miss_then_hit(0, 16'h0010, 16'hABCD, "t3c");
    ire = 0;
    // 4: write invalidates cached line, and wins against a coincident fill
    iwrite(16'h0010, 16'h1234);
    miss_then_hit(0, 16'h0010, 16'h1234, "t4a");
    ire = 0;
    ire[1] = 1; iaddr[31:16] = 16'h0010;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t4b_stall", {31'b0, istall[1]}, 1);
      if (i == 7) begin iwe = 1; iwaddr = 16'h0010; iwdata = 16'h5678; end
      tick();
      iwe = 0;
    end
    miss_then_hit(1, 16'h0010, 16'h5678, "t4c");
    ire = 0;
    miss_then_hit(0, 16'h0010, 16'h5678, "t4d");
    // 5: gwe low for 5 cycles mid-fill stretches the stall to 13
    ire = 2'b01; iaddr[15:0] = 16'h0020; n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!istall[0]) break;
      n++;
      gwe = (c >= 3 && c < 8) ? 0 : 1;
      tick();
    end
    gwe = 1;
    chk("t5_gwe_len", n, 13);
    chk("t5_gwe_data", {16'b0, iout[15:0]}, 32'h1111);
    // 5b: reset mid-fill
    iaddr[15:0] = 16'h0031;
    tick(); tick(); tick();
    rst = 0;
    tick();
    chk("t5_rst_stall", {31'b0, istall[0]}, 0);
    chk("t5_rst_iout", {16'b0, iout[15:0]}, 0);
    rst = 1;
    miss_then_hit(0, 16'h0031, 16'h2222, "t5c");
    miss_then_hit(0, 16'h0020, 16'h1111, "t5d");
    ire = 0;
    // 6: data memory read-during-write returns old value
    dwe = 1; dwaddr = 5; din = 16'h00FF; dre = 1; draddr = 5;
    #1 chk("t6_rdw_old", {16'b0, dout}, 0);
    tick();
    dwe = 0;
    chk("t6_rdw_new", {16'b0, dout}, 32'h00FF);
    gwe = 0; dwe = 1; dwaddr = 3; din = 16'hBEEF;
    tick();
    gwe = 1; dwe = 0; draddr = 3;
    #1 chk("t6_gwe_hold", {16'b0, dout}, 0);
    dre = 0; draddr = 5;
    #1 chk("t6_dre_off", {16'b0, dout}, 0);
    // 6b: bypassed build reads the store directly and never stalls
    ire = 2'b11; iaddr = {16'h0031, 16'h0010};
    #1 chk("t6_nc_data", iout_nc, {16'h2222, 16'h5678});
    chk("t6_nc_stall", {30'b0, istall_nc}, 0);
    tick();
    chk("t6_nc_never_stalled", {31'b0, nc_stalled}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
